serial_tx_framer: RTL and testbench
===================================

# serial_tx_framer

Parametrised serial transmitter that serialises one DATA_W-bit word per frame: start bit, data, optional even or odd parity, then one or two stop bits. Each bit is held for CLKS_PER_BIT clocks. Words enter through a valid/ready handshake, and back-to-back frames are sent with no idle gap. The block drives the serial link toward a receiver or pin and replaces the fixed 7-bit, even-parity, one-clock-per-bit transmitter.

## Interface
- DATA_W, 7: payload bits per frame, legal range 1..16.
- PARITY, 1: parity mode. 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- CLKS_PER_BIT, 1: clocks per bit, ≥1.
- LSB_FIRST, 1: 1 sends data bit 0 first; 0 sends bit DATA_W-1 first.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a word to send.
- in_ready  out  1  block accepts a word on this cycle.
- in_data  in  DATA_W  payload word.
- serial_out  out  1  serial line, idles high.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse in the last clock of the final stop bit.

## Operation
- One clock. Reset is asynchronous and active-high.
- Frame length F = 1 + DATA_W + (PARITY != 0) + STOP_BITS bits.
- A word is accepted on a rising edge where in_valid and in_ready are both 1.
  - in_data is latched into a shift register at acceptance; later changes to in_data do not affect the frame.
- Parity is computed on the latched word.
  - Even: parity bit = XOR of all data bits.
  - Odd: parity bit = inverted XOR of all data bits.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START on acceptance.
  - START → DATA after CLKS_PER_BIT clocks.
  - DATA → PAR, or → STOP when PARITY = 0, after DATA_W bit periods.
  - PAR → STOP after one bit period.
  - STOP → IDLE after STOP_BITS bit periods, or → START if a word is accepted in the last STOP cycle.
- Counters:
  - Clock counter: 0..CLKS_PER_BIT-1, wraps at each bit end.
  - Bit index: 0..DATA_W-1 in DATA, 0..STOP_BITS-1 in STOP. Width is $clog2 of the maximum count, and at least 1.
- Outputs by state:
  - serial_out = 1 in IDLE and STOP, 0 in START, the current data bit in DATA, the parity bit in PAR.
  - in_ready = !rst && (state == IDLE || last clock of the final stop bit).
  - busy = (state != IDLE).
- Illegal parameter values are rejected at elaboration with $error.

## Timing
- Reset values while rst is high: serial_out = 1, in_ready = 0, busy = 0, frame_done = 0, state = IDLE, counters = 0.
- in_ready rises in the first cycle after rst deasserts.
- Acceptance at edge k:
  - Start bit appears on serial_out after edge k and lasts through edge k+C, where C = CLKS_PER_BIT.
  - Bit j of the frame occupies the cycles after edges k+jC through k+(j+1)C.
  - The frame spans exactly F·C clocks.
- Back-to-back: accepting in the last stop cycle puts the next start bit on the very next cycle. The line never idles between frames.
- frame_done is high for exactly one cycle: the last clock of the final stop bit. It coincides with in_ready = 1.
- in_valid while in_ready = 0 is ignored. The word is not consumed, and the sender holds it.
- Reset mid-frame: serial_out returns to 1 immediately (asynchronous), the frame is aborted, no frame_done is issued, and no word is retained.
- With C = 1, the block emits one bit per clock. Latency from acceptance to start bit is 1 cycle.

## Structure
- Shared package serial_pkg holds:
  - PARITY_NONE, PARITY_EVEN, PARITY_ODD constants.
  - A state enum type.
  - A function frame_bits(DATA_W, PARITY, STOP_BITS) returning F.
- One sub-module, serial_bit_timer:
  - Parameter CLKS_PER_BIT.
  - Inputs: clk, rst, run.
  - Output: bit_end, a pulse on the last clock of each bit period.
- The FSM, shift register, parity logic and handshake live in serial_tx_framer.

## Test plan
- Defaults, in_data = 7'b1010011, one-cycle valid → serial_out 0,1,1,0,0,1,0,1,0,1 over cycles k+1..k+10, busy high for 10 cycles, frame_done at k+10.
- DATA_W=8, PARITY=2, STOP_BITS=2, CLKS_PER_BIT=4, in_data = 8'hA5 → 12 bits of 4 clocks each (48 clocks), parity bit 1, two high stop bits, in_ready low throughout except the last clock.
- PARITY=0, LSB_FIRST=0, in_data = 7'h41 → 0,1,0,0,0,0,0,1,1 (9 bits), no parity slot.
- in_valid held high with words 7'h55 then 7'h2A → second start bit immediately follows the first stop bit with no idle cycle, and two frame_done pulses 10 cycles apart.
- in_data changed to 7'h7F one cycle after accepting 7'h00 → transmitted payload is all zeros, parity bit 0.
- rst asserted during data bit 3 (CLKS_PER_BIT=4) → serial_out = 1 the same cycle, busy = 0, no frame_done, in_ready = 1 one cycle after rst deasserts, and the next frame is sent correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit framer: parity modes, FSM states
// and the frame-length helper.
package serial_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Counts clocks within one bit period while run is high; bit_end marks the
// last clock of each period.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero while idle so a new frame always starts on a full bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || cnt_q == LAST) cnt_d = '0;
    else                       cnt_d = cnt_q + CW'(1);
  end

  assign bit_end = run && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_tx_framer.sv
// Serial transmitter: start bit, DATA_W data bits, optional parity, 1-2 stop
// bits, each held CLKS_PER_BIT clocks; back-to-back frames without idle gap.
module serial_tx_framer
  import serial_pkg::*;
#(
  parameter int DATA_W       = 7,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
    $error("serial_tx_framer: DATA_W must be in 1..16");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
    $error("serial_tx_framer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("serial_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("serial_tx_framer: CLKS_PER_BIT must be at least 1");
  end
  if (LSB_FIRST < 0 || LSB_FIRST > 1) begin : g_bad_order
    $error("serial_tx_framer: LSB_FIRST must be 0 or 1");
  end

  localparam int MAXC = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int IW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_W - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              bit_end;
  logic              last_stop;
  logic              accept;
  logic              data_bit;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (busy),
    .bit_end(bit_end)
  );

  assign busy       = (state_q != IDLE);
  assign last_stop  = (state_q == STOP) && bit_end && (idx_q == LAST_STOP);
  assign in_ready   = !rst && ((state_q == IDLE) || last_stop);
  assign accept     = in_valid && in_ready;
  assign frame_done = last_stop;
  assign data_bit   = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DATA_W-1];

  always_comb begin
    serial_out = 1'b1;
    case (state_q)
      START:   serial_out = 1'b0;
      DATA:    serial_out = data_bit;
      PAR:     serial_out = par_q;
      default: serial_out = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    // Loading in the final stop cycle is what makes back-to-back frames gapless.
    if (accept) begin
      shreg_d = in_data;
      par_d   = (^in_data) ^ (PARITY == PARITY_ODD);
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = accept ? START : IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Payload and parity are only observed in DATA/PAR, so they carry no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: three parameterisations checked every cycle
// against a per-bit expected-line queue, plus directed frame captures.
module tb_serial_tx_framer;

  localparam int DW [3]  = '{7, 8, 7};
  localparam int PR [3]  = '{1, 2, 0};
  localparam int SB [3]  = '{1, 2, 1};
  localparam int CPB[3]  = '{1, 4, 1};
  localparam int LSB[3]  = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        vld[3];
  logic [15:0] dat[3];
  logic        rdy[3];
  logic        so [3];
  logic        bsy[3];
  logic        fd [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  bit exp_q[3][$];
  bit acc[3];

  always #5 clk = ~clk;

  serial_tx_framer #(.DATA_W(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(1), .LSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0][6:0]),
    .serial_out(so[0]), .busy(bsy[0]), .frame_done(fd[0]));

  serial_tx_framer #(.DATA_W(8), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(4), .LSB_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1][7:0]),
    .serial_out(so[1]), .busy(bsy[1]), .frame_done(fd[1]));

  serial_tx_framer #(.DATA_W(7), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(1), .LSB_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(dat[2][6:0]),
    .serial_out(so[2]), .busy(bsy[2]), .frame_done(fd[2]));

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  // Frame as transmitted, one character per bit, straight from the framing rules.
  function automatic string frame_str(input int i, input logic [15:0] d);
    string s;
    int    ones;
    s    = "0";
    ones = 0;
    for (int b = 0; b < DW[i]; b++) begin
      int k;
      k    = (LSB[i] != 0) ? b : DW[i] - 1 - b;
      s    = {s, d[k] ? "1" : "0"};
      ones = ones + int'(d[b]);
    end
    if (PR[i] == 1) s = {s, (ones % 2 == 1) ? "1" : "0"};
    if (PR[i] == 2) s = {s, (ones % 2 == 1) ? "0" : "1"};
    for (int b = 0; b < SB[i]; b++) s = {s, "1"};
    return s;
  endfunction

  function automatic string expand(input string s, input int c);
    string o;
    o = "";
    for (int j = 0; j < s.len(); j++)
      for (int r = 0; r < c; r++) o = {o, s.substr(j, j)};
    return o;
  endfunction

  function automatic string rep(input string ch, input int n);
    string o;
    o = "";
    for (int j = 0; j < n; j++) o = {o, ch};
    return o;
  endfunction

  // Reference: queue of line values for upcoming cycles; ready when at most the
  // final stop clock remains.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        exp_q[i].delete();
        acc[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        string f;
        acc[i] = vld[i] && (exp_q[i].size() <= 1);
        if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
        if (acc[i]) begin
          f = frame_str(i, dat[i]);
          for (int j = 0; j < f.len(); j++)
            for (int r = 0; r < CPB[i]; r++) exp_q[i].push_back(f[j] == 8'h31);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int sz;
      sz = exp_q[i].size();
      chk($sformatf("serial_out[%0d]", i), int'(so[i]), (sz == 0) ? 1 : int'(exp_q[i][0]));
      chk($sformatf("busy[%0d]", i), int'(bsy[i]), (sz != 0) ? 1 : 0);
      chk($sformatf("frame_done[%0d]", i), int'(fd[i]), (sz == 1) ? 1 : 0);
      chk($sformatf("in_ready[%0d]", i), int'(rdy[i]), (!rst && sz <= 1) ? 1 : 0);
    end
  end

  task automatic send(input int i, input logic [15:0] d);
    int t;
    t      = 0;
    vld[i] = 1'b1;
    dat[i] = d;
    @(negedge clk);
    while (!rdy[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[i]) begin
      total_cnt++;
      $display("FAIL send[%0d] timeout: in_ready got 0 for 200 cycles, expected 1", i);
    end
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
  endtask

  task automatic capture(input int i, input int n, output string s_so, output string s_rdy,
                         output string s_fd, output int nbusy);
    s_so  = "";
    s_rdy = "";
    s_fd  = "";
    nbusy = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      s_so  = {s_so, so[i] ? "1" : "0"};
      s_rdy = {s_rdy, rdy[i] ? "1" : "0"};
      s_fd  = {s_fd, fd[i] ? "1" : "0"};
      nbusy = nbusy + int'(bsy[i]);
    end
  endtask

  initial begin
    string s_so, s_rdy, s_fd;
    int    nb, t;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    @(negedge clk);
    chk("reset serial_out", int'(so[0]), 1);
    chk("reset in_ready", int'(rdy[0]), 0);
    chk("reset busy", int'(bsy[1]), 0);
    chk("reset frame_done", int'(fd[1]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", int'(rdy[0]), 1);

    chk_s("model 7'b1010011", frame_str(0, 16'h0053), "0110010101");
    chk_s("model 8'hA5 odd", frame_str(1, 16'h00A5), "010100101111");
    chk_s("model 7'h41 msb", frame_str(2, 16'h0041), "010000011");
    chk_s("model 7'h55", frame_str(0, 16'h0055), "0101010101");
    chk_s("model 7'h2A", frame_str(0, 16'h002A), "0010101011");

    send(0, 16'h0053);
    capture(0, 10, s_so, s_rdy, s_fd, nb);
    chk_s("t1 line", s_so, "0110010101");
    chk_s("t1 frame_done", s_fd, "0000000001");
    chk("t1 busy cycles", nb, 10);

    send(1, 16'h00A5);
    capture(1, 48, s_so, s_rdy, s_fd, nb);
    chk_s("t2 line", s_so, expand("010100101111", 4));
    chk_s("t2 in_ready", s_rdy, {rep("0", 47), "1"});
    chk_s("t2 frame_done", s_fd, {rep("0", 47), "1"});
    chk("t2 busy cycles", nb, 48);

    send(2, 16'h0041);
    capture(2, 9, s_so, s_rdy, s_fd, nb);
    chk_s("t3 line", s_so, "010000011");
    chk("t3 busy cycles", nb, 9);

    vld[0] = 1'b1;
    dat[0] = 16'h0055;
    t = 0;
    @(negedge clk);
    while (!rdy[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t4 first accept ready", int'(rdy[0]), 1);
    @(posedge clk);
    #1 dat[0] = 16'h002A;
    s_so = "";
    s_fd = "";
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s_so = {s_so, so[0] ? "1" : "0"};
      s_fd = {s_fd, fd[0] ? "1" : "0"};
      if (rdy[0] && vld[0]) begin
        @(posedge clk);
        #1 vld[0] = 1'b0;
      end
    end
    vld[0] = 1'b0;
    chk_s("t4 back-to-back line", s_so, "01010101010010101011");
    chk_s("t4 frame_done pair", s_fd, "00000000010000000001");

    send(0, 16'h0000);
    dat[0] = 16'h007F;
    capture(0, 10, s_so, s_rdy, s_fd, nb);
    chk_s("t5 latched payload", s_so, "0000000001");

    send(1, 16'h00C3);
    repeat (18) @(posedge clk);
    #2;
    chk("t6 data bit 3 before reset", int'(so[1]), 0);
    #1 rst = 1'b1;
    #1;
    chk("t6 serial_out on reset", int'(so[1]), 1);
    chk("t6 busy on reset", int'(bsy[1]), 0);
    chk("t6 frame_done on reset", int'(fd[1]), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6 in_ready after reset", int'(rdy[1]), 1);
    send(1, 16'h00A5);
    capture(1, 48, s_so, s_rdy, s_fd, nb);
    chk_s("t6 frame after reset", s_so, expand("010100101111", 4));

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (!(vld[i] && !acc[i])) begin
          vld[i] = ($urandom_range(0, 3) != 0);
          dat[i] = 16'($urandom);
        end
      end
      if (cyc == 700) begin
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("drain idle [1]", int'(bsy[1]), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
